// File: rtl/sp_ram_pkg.sv
// Shared widths and FSM state encoding for the single-port RAM arbiter.
package sp_ram_pkg;

  localparam int SP_ADDR_W = 4;
  localparam int SP_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the
// requester that did not win last time.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_winner,
  output logic gnt0,
  output logic gnt1
);

  always_comb begin
    gnt0 = req0 & (~req1 | last_winner);
    gnt1 = req1 & (~req0 | ~last_winner);
  end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two requesters,
// with optional locked bursts of up to MAX_BURST accesses.
//
// state   | meaning
// IDLE    | no owner, plain round-robin
// OWN0    | requester 0 holds the RAM while req0 stays high
// OWN1    | requester 1 holds the RAM while req1 stays high
module sp_ram_arbiter
  import sp_ram_pkg::*;
#(
  parameter int ADDR_W    = SP_ADDR_W,
  parameter int DATA_W    = SP_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  state_t             state, state_nxt;
  logic               last_winner, lw_nxt;
  logic [CNT_W-1:0]   burst_cnt, cnt_nxt, cnt_inc;
  logic               arb_gnt0, arb_gnt1;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  din_q;

  rr_arb2 u_arb (
    .req0        (req0),
    .req1        (req1),
    .last_winner (last_winner),
    .gnt0        (arb_gnt0),
    .gnt1        (arb_gnt1)
  );

  // Grants are gated by rst_n so nothing reaches the RAM during reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (state == ST_OWN0 && req0) begin
        gnt0 = 1'b1;
      end else if (state == ST_OWN1 && req1) begin
        gnt1 = 1'b1;
      end else begin
        gnt0 = arb_gnt0;
        gnt1 = arb_gnt1;
      end
    end
  end

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = addr_q;
    ram_din  = din_q;
    if (gnt0) begin
      ram_we   = we0;
      ram_addr = addr0;
      ram_din  = wdata0;
    end else if (gnt1) begin
      ram_we   = we1;
      ram_addr = addr1;
      ram_din  = wdata1;
    end
  end

  // The burst count only carries over while the same owner keeps its grant.
  always_comb begin
    state_nxt = ST_IDLE;
    cnt_nxt   = '0;
    cnt_inc   = '0;
    lw_nxt    = last_winner;
    if (gnt0) begin
      lw_nxt  = 1'b0;
      cnt_inc = ((state == ST_OWN0) ? burst_cnt : '0) + CNT_W'(1);
      if (lock0 && (cnt_inc < CNT_W'(MAX_BURST))) begin
        state_nxt = ST_OWN0;
        cnt_nxt   = cnt_inc;
      end
    end else if (gnt1) begin
      lw_nxt  = 1'b1;
      cnt_inc = ((state == ST_OWN1) ? burst_cnt : '0) + CNT_W'(1);
      if (lock1 && (cnt_inc < CNT_W'(MAX_BURST))) begin
        state_nxt = ST_OWN1;
        cnt_nxt   = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      last_winner <= 1'b1;
      burst_cnt   <= '0;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
    end else begin
      state       <= state_nxt;
      last_winner <= lw_nxt;
      burst_cnt   <= cnt_nxt;
      rvalid0     <= gnt0 & ~we0;
      rvalid1     <= gnt1 & ~we1;
      addr_q      <= ram_addr;
      din_q       <= ram_din;
    end
  end

  assign rdata = ram_dout;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench for sp_ram_arbiter with a behavioural registered-read RAM.
module tb_sp_ram_arbiter;
  import sp_ram_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, we0, we1, lock0, lock1;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1, ram_we;
  logic [7:0] rdata, ram_din, ram_dout;
  logic [3:0] ram_addr;
  logic [7:0] mem [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sp_ram_arbiter #(.ADDR_W(4), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  typedef struct {
    logic       r0, r1, w0, w1, l0, l1;
    logic [3:0] a0, a1;
    logic [7:0] d0, d1;
    logic       g0, g1, we;
    logic [3:0] ea;
    logic [7:0] ed;
    logic       v0, v1;
    logic [7:0] rd;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  function automatic vec_t mk(int r0, int r1, int w0, int w1, int l0, int l1,
                              int a0, int a1, int d0, int d1,
                              int g0, int g1, int we, int ea, int ed,
                              int v0, int v1, int rd);
    vec_t v;
    v.r0 = r0[0]; v.r1 = r1[0]; v.w0 = w0[0]; v.w1 = w1[0];
    v.l0 = l0[0]; v.l1 = l1[0];
    v.a0 = a0[3:0]; v.a1 = a1[3:0]; v.d0 = d0[7:0]; v.d1 = d1[7:0];
    v.g0 = g0[0]; v.g1 = g1[0]; v.we = we[0];
    v.ea = ea[3:0]; v.ed = ed[7:0];
    v.v0 = v0[0]; v.v1 = v1[0]; v.rd = rd[7:0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic r1, input logic w0, input logic w1,
                       input logic l0, input logic l1, input logic [3:0] a0,
                       input logic [3:0] a1, input logic [7:0] d0, input logic [7:0] d1);
    req0 = r0; req1 = r1; we0 = w0; we1 = w1; lock0 = l0; lock1 = l1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    // contention, both unlocked writers
    for (int i = 0; i < 4; i++)
      vecs[i] = mk(1,1,1,1,0,0,3,4,'h11,'h22, (i%2==0)?1:0, (i%2==0)?0:1, 1,
                   (i%2==0)?3:4, (i%2==0)?'h11:'h22, 0,0,0);
    // single writer then reads
    vecs[4]  = mk(1,0,1,0,0,0,0,0,'h81,0, 1,0,1,0,'h81, 0,0,0);
    vecs[5]  = mk(1,0,1,0,0,0,1,0,'hEA,0, 1,0,1,1,'hEA, 0,0,0);
    vecs[6]  = mk(1,0,1,0,0,0,2,0,'hFF,0, 1,0,1,2,'hFF, 0,0,0);
    vecs[7]  = mk(1,0,0,0,0,0,0,0,0,0,    1,0,0,0,0,     0,0,0);
    vecs[8]  = mk(1,0,0,0,0,0,1,0,0,0,    1,0,0,1,0,     1,0,'h81);
    vecs[9]  = mk(1,0,0,0,0,0,2,0,0,0,    1,0,0,2,0,     1,0,'hEA);
    vecs[10] = mk(0,0,0,0,0,0,0,0,0,0,    0,0,0,2,0,     1,0,'hFF);
    // readback of contention writes
    vecs[11] = mk(1,0,0,0,0,0,3,0,0,0,    1,0,0,3,0,     0,0,0);
    vecs[12] = mk(1,0,0,0,0,0,4,0,0,0,    1,0,0,4,0,     1,0,'h11);
    vecs[13] = mk(0,0,0,0,0,0,0,0,0,0,    0,0,0,4,0,     1,0,'h22);
    // interleaved reads
    vecs[14] = mk(1,0,0,0,0,0,1,0,0,0,    1,0,0,1,0,     0,0,0);
    vecs[15] = mk(0,1,0,0,0,0,0,2,0,0,    0,1,0,2,0,     1,0,'hEA);
    vecs[16] = mk(0,0,0,0,0,0,0,0,0,0,    0,0,0,2,0,     0,1,'hFF);
    // locked burst capped at four, requester 1 waiting
    vecs[17] = mk(1,1,1,1,1,0,5,11,'h50,'hBB, 1,0,1,5,'h50, 0,0,0);
    vecs[18] = mk(1,1,1,1,1,0,6,11,'h51,'hBB, 1,0,1,6,'h51, 0,0,0);
    vecs[19] = mk(1,1,1,1,1,0,7,11,'h52,'hBB, 1,0,1,7,'h52, 0,0,0);
    vecs[20] = mk(1,1,1,1,1,0,8,11,'h53,'hBB, 1,0,1,8,'h53, 0,0,0);
    vecs[21] = mk(1,1,1,1,1,0,9,11,'h54,'hBB, 0,1,1,11,'hBB, 0,0,0);
    vecs[22] = mk(1,0,1,0,1,0,9,0,'h54,0,     1,0,1,9,'h54,  0,0,0);
    vecs[23] = mk(1,0,1,0,0,0,10,0,'h55,0,    1,0,1,10,'h55, 0,0,0);
    vecs[24] = mk(1,0,0,0,0,0,8,0,0,0,        1,0,0,8,0,     0,0,0);
    vecs[25] = mk(0,1,0,0,0,0,0,11,0,0,       0,1,0,11,0,    1,0,'h53);
    vecs[26] = mk(0,0,0,0,0,0,0,0,0,0,        0,0,0,11,0,    0,1,'hBB);

    // reset forces outputs low even with a pending write request
    rst_n = 1'b0;
    drive(1,0,1,0,0,0,4'h5,4'h0,8'hAA,8'h00);
    #12;
    chk("rst.gnt0", 32'(gnt0), 32'd0);
    chk("rst.gnt1", 32'(gnt1), 32'd0);
    chk("rst.ram_we", 32'(ram_we), 32'd0);
    chk("rst.rvalid0", 32'(rvalid0), 32'd0);
    chk("rst.rvalid1", 32'(rvalid1), 32'd0);
    chk("rst.ram_addr", 32'(ram_addr), 32'd0);
    chk("rst.ram_din", 32'(ram_din), 32'd0);
    drive(0,0,0,0,0,0,0,0,0,0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].r0, vecs[i].r1, vecs[i].w0, vecs[i].w1, vecs[i].l0, vecs[i].l1,
            vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
      @(negedge clk);
      chk($sformatf("v%0d.gnt0", i), 32'(gnt0), 32'(vecs[i].g0));
      chk($sformatf("v%0d.gnt1", i), 32'(gnt1), 32'(vecs[i].g1));
      chk($sformatf("v%0d.ram_we", i), 32'(ram_we), 32'(vecs[i].we));
      chk($sformatf("v%0d.ram_addr", i), 32'(ram_addr), 32'(vecs[i].ea));
      if (vecs[i].we) chk($sformatf("v%0d.ram_din", i), 32'(ram_din), 32'(vecs[i].ed));
      chk($sformatf("v%0d.rvalid0", i), 32'(rvalid0), 32'(vecs[i].v0));
      chk($sformatf("v%0d.rvalid1", i), 32'(rvalid1), 32'(vecs[i].v1));
      if (vecs[i].v0 | vecs[i].v1) chk($sformatf("v%0d.rdata", i), 32'(rdata), 32'(vecs[i].rd));
      @(posedge clk); #1;
    end

    // lock released early: owner drops req, waiting requester wins same cycle
    drive(1,0,1,0,1,0,4'd12,4'd0,8'h5A,8'h00);
    @(negedge clk);
    chk("early.gnt0", 32'(gnt0), 32'd1);
    @(posedge clk); #1;
    chk("early.own0", 32'(dut.state), 32'(ST_OWN0));
    drive(0,1,0,1,0,0,4'd0,4'd13,8'h00,8'hA5);
    @(negedge clk);
    chk("early.gnt1", 32'(gnt1), 32'd1);
    chk("early.gnt0_off", 32'(gnt0), 32'd0);
    @(posedge clk); #1;
    chk("early.idle", 32'(dut.state), 32'(ST_IDLE));

    // reset during a locked burst with a read in flight
    drive(1,0,0,0,1,0,4'd1,4'd0,8'h00,8'h00);
    @(negedge clk);
    chk("mid.gnt0", 32'(gnt0), 32'd1);
    @(posedge clk); #1;
    chk("mid.rvalid0", 32'(rvalid0), 32'd1);
    chk("mid.rdata", 32'(rdata), 32'hEA);
    drive(1,1,1,1,1,0,4'd14,4'd15,8'h77,8'h88);
    #1;
    chk("mid.own_gnt0", 32'(gnt0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid.rst_gnt0", 32'(gnt0), 32'd0);
    chk("mid.rst_gnt1", 32'(gnt1), 32'd0);
    chk("mid.rst_ram_we", 32'(ram_we), 32'd0);
    chk("mid.rst_rvalid0", 32'(rvalid0), 32'd0);
    chk("mid.rst_ram_addr", 32'(ram_addr), 32'd0);
    @(posedge clk); #2;
    chk("mid.no_write14", 32'(mem[14]), 32'd0);
    chk("mid.no_write15", 32'(mem[15]), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("mid.idle", 32'(dut.state), 32'(ST_IDLE));
    @(negedge clk);
    chk("mid.tie_gnt0", 32'(gnt0), 32'd1);
    chk("mid.tie_gnt1", 32'(gnt1), 32'd0);
    chk("mid.rvalid0_after", 32'(rvalid0), 32'd0);
    @(posedge clk); #1;
    chk("mid.write14", 32'(mem[14]), 32'h77);
    drive(0,0,0,0,0,0,0,0,0,0);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
